// File: rtl/siso_shift_reg.sv
// Serial-in/serial-out shift register with parallel observability and fill flag.
// Bit 0 of par_q holds the newest sample, bit DEPTH-1 the oldest (driven on q).
module siso_shift_reg #(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             si,
  output logic             q,
  output logic [DEPTH-1:0] par_q,
  output logic             full
);

  localparam int unsigned     CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEPTH);

  logic [DEPTH-1:0] r_sr;
  logic [CW-1:0]    r_cnt;

  // Shift-and-insert form stays legal for DEPTH=1, where a [DEPTH-2:0] slice would not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else if (en) begin
      r_sr <= (r_sr << 1) | DEPTH'(si);
      if (r_cnt != CNT_MAX)
        r_cnt <= r_cnt + CW'(1);
    end
  end

  assign q     = r_sr[DEPTH-1];
  assign par_q = r_sr;
  assign full  = (r_cnt == CNT_MAX);

endmodule

// File: tb/tb_siso_shift_reg.sv
// Self-checking bench for siso_shift_reg at DEPTH 4, 1 and 16, sharing one stimulus stream
// checked against a history-of-accepted-bits reference model.
module tb_siso_shift_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  logic si  = 1'b0;

  logic        q4,  q1,  q16;
  logic [3:0]  par4;
  logic [0:0]  par1;
  logic [15:0] par16;
  logic        full4, full1, full16;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Bits accepted since the last reset, oldest first.
  bit hist[$];

  always #5 clk = ~clk;

  siso_shift_reg #(.DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .si(si), .q(q4), .par_q(par4), .full(full4)
  );
  siso_shift_reg #(.DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .si(si), .q(q1), .par_q(par1), .full(full1)
  );
  siso_shift_reg #(.DEPTH(16)) u_d16 (
    .clk(clk), .rst(rst), .en(en), .si(si), .q(q16), .par_q(par16), .full(full16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected contents: the newest d accepted bits, newest at bit 0, zeros where none yet.
  function automatic logic [63:0] exp_par(input int unsigned d);
    logic [63:0] v;
    int unsigned n;
    v = '0;
    n = hist.size();
    for (int unsigned i = 0; i < d; i++)
      if (i < n) v[i] = hist[n - 1 - i];
    return v;
  endfunction

  function automatic logic exp_full(input int unsigned d);
    return hist.size() >= d;
  endfunction

  task automatic model_checks();
    logic [63:0] e4, e1, e16;
    e4  = exp_par(4);
    e1  = exp_par(1);
    e16 = exp_par(16);
    check("d4_par",   64'(par4),   e4);
    check("d4_q",     64'(q4),     64'(e4[3]));
    check("d4_full",  64'(full4),  64'(exp_full(4)));
    check("d1_par",   64'(par1),   e1);
    check("d1_q",     64'(q1),     64'(e1[0]));
    check("d1_full",  64'(full1),  64'(exp_full(1)));
    check("d16_par",  64'(par16),  e16);
    check("d16_q",    64'(q16),    64'(e16[15]));
    check("d16_full", 64'(full16), 64'(exp_full(16)));
  endtask

  // Drive one clock edge, advance the model, then sample 1 time unit after the edge.
  task automatic tick(input logic r, input logic e, input logic s);
    rst = r;
    en  = e;
    si  = s;
    @(posedge clk);
    if (r) hist.delete();
    else if (e) begin
      hist.push_back(s);
      if (hist.size() > 64) void'(hist.pop_front());
    end
    #1;
    model_checks();
  endtask

  initial begin
    logic [3:0] pat;
    logic [3:0] exp_q;

    @(negedge clk);

    // Reset dominates en/si.
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    check("rst_q",    64'(q4),    64'(0));
    check("rst_par",  64'(par4),  64'(0));
    check("rst_full", 64'(full4), 64'(0));

    // Delay through four stages.
    pat   = 4'b0101;  // si = 1,0,1,0 on edges 1..4 (bit i -> edge i+1)
    exp_q = 4'b1000;
    for (int unsigned i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, pat[i]);
      check("dly_q", 64'(q4), 64'(exp_q[i]));
      check("dly_full", 64'(full4), 64'(i == 3));
    end
    check("dly_par", 64'(par4), 64'(4'b1010));
    exp_q = 4'b0010;  // q after edges 5..7 = 0,1,0
    for (int unsigned i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0);
      check("drain_q", 64'(q4), 64'(exp_q[i]));
    end

    // Load 1100, then hold with en low while si toggles.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0);
    check("load_par", 64'(par4), 64'(4'b1100));
    for (int unsigned i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'(i[0] ^ 1'b1));
      check("hold_par",  64'(par4),  64'(4'b1100));
      check("hold_q",    64'(q4),    64'(1));
      check("hold_full", 64'(full4), 64'(1));
    end

    // Reset mid-stream discards in-flight bits.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    check("mid_par", 64'(par4), 64'(4'b0011));
    tick(1'b1, 1'b1, 1'b1);
    check("mid_rst_par",  64'(par4),  64'(0));
    check("mid_rst_full", 64'(full4), 64'(0));
    for (int unsigned i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 1'(i == 0));
      check("mid_q", 64'(q4), 64'(i == 3));
    end

    // Random stream with occasional resets, all depths checked by the model each edge.
    for (int unsigned i = 0; i < 600; i++)
      tick(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));

    // Long enabled run so the deepest instance is guaranteed to saturate.
    tick(1'b1, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 40; i++)
      tick(1'b0, 1'b1, 1'($urandom));
    check("sat_full16", 64'(full16), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
